// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory responder for the MEM stage: one access in flight, programmable latency.
// Optional byte-strobed stores when DATA_MEM_BYTE_STRB_EN is defined (adds req_strb).
module data_mem_responder #(
   parameter int DEPTH_WORDS = 64,
   parameter int LATENCY     = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   input  logic        req_write,
   input  logic [63:0] req_addr,
   input  logic [63:0] req_wdata,
`ifdef DATA_MEM_BYTE_STRB_EN
   input  logic [7:0]  req_strb,
`endif
   output logic        req_ready,
   output logic        resp_valid,
   output logic [63:0] resp_rdata,
   output logic        resp_err,
   output logic        stall
);
   localparam int AW = $clog2(DEPTH_WORDS);

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

   state_t          state, state_next;
   logic [3:0]      cnt;
   logic            wr_q;
   logic            mis_q;
   logic [AW-1:0]   idx_q;
   logic [63:0]     wdata_q;
`ifdef DATA_MEM_BYTE_STRB_EN
   logic [7:0]      strb_q;
`endif
   logic [63:0]     mem [DEPTH_WORDS];
   logic            accept;
   logic            exec;
   logic            unused_addr;

   assign accept      = req_valid & req_ready;
   assign exec        = (state == BUSY) && (cnt == 4'd0);
   // Upper address bits are intentionally ignored so addresses wrap.
   assign unused_addr = ^req_addr[63:AW+3];

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (accept) state_next = BUSY;
         BUSY:    if (exec)   state_next = RESP;
         RESP:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      req_ready  = (state == IDLE);
      resp_valid = (state == RESP);
      stall      = ((state == IDLE) && req_valid) || (state == BUSY);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt        <= 4'd0;
         resp_rdata <= 64'd0;
         resp_err   <= 1'b0;
         wr_q       <= 1'b0;
         mis_q      <= 1'b0;
         idx_q      <= '0;
         wdata_q    <= 64'd0;
`ifdef DATA_MEM_BYTE_STRB_EN
         strb_q     <= 8'd0;
`endif
         for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= 64'd0;
      end else begin
         if (accept) begin
            cnt     <= 4'(LATENCY - 1);
            wr_q    <= req_write;
            mis_q   <= (req_addr[2:0] != 3'd0);
            idx_q   <= req_addr[AW+2:3];
            wdata_q <= req_wdata;
`ifdef DATA_MEM_BYTE_STRB_EN
            strb_q  <= req_strb;
`endif
         end else if ((state == BUSY) && (cnt != 4'd0)) begin
            cnt <= cnt - 4'd1;
         end

         if (exec) begin
            if (mis_q) begin
               resp_rdata <= 64'd0;
               resp_err   <= 1'b1;
            end else if (wr_q) begin
`ifdef DATA_MEM_BYTE_STRB_EN
               for (int b = 0; b < 8; b++)
                  if (strb_q[b]) mem[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
`else
               mem[idx_q] <= wdata_q;
`endif
               resp_rdata <= 64'd0;
               resp_err   <= 1'b0;
            end else begin
               resp_rdata <= mem[idx_q];
               resp_err   <= 1'b0;
            end
         end
      end
   end
endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: vector table plus back-to-back and reset-in-flight sequences.
module tb_data_mem_responder;
   localparam int DEPTH = 64;
   localparam int LAT   = 2;
   localparam int P     = LAT + 2;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid, req_write;
   logic [63:0] req_addr, req_wdata;
   logic [7:0]  req_strb;
   logic        req_ready, resp_valid, resp_err, stall;
   logic [63:0] resp_rdata;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata),
`ifdef DATA_MEM_BYTE_STRB_EN
      .req_strb(req_strb),
`endif
      .req_ready(req_ready), .resp_valid(resp_valid),
      .resp_rdata(resp_rdata), .resp_err(resp_err), .stall(stall)
   );

   typedef struct {
      string       name;
      logic        wr;
      logic [63:0] addr;
      logic [63:0] wdata;
      logic [7:0]  strb;
      logic [63:0] exp_rdata;
      logic        exp_err;
   } vec_t;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // One isolated transaction from IDLE; req_* are scrambled after acceptance.
   task automatic txn(input vec_t v);
      @(negedge clk);
      req_valid = 1'b1; req_write = v.wr; req_addr = v.addr;
      req_wdata = v.wdata; req_strb = v.strb;
      #1;
      chk({v.name, " ready"}, 64'(req_ready), 64'd1);
      chk({v.name, " stall_acc"}, 64'(stall), 64'd1);
      @(posedge clk); #1;
      req_valid = 1'b0; req_write = ~v.wr; req_addr = ~v.addr;
      req_wdata = ~v.wdata; req_strb = ~v.strb;
      for (int i = 0; i < LAT; i++) begin
         @(negedge clk);
         chk({v.name, " stall_busy"}, 64'(stall), 64'd1);
         chk({v.name, " no_resp_busy"}, 64'(resp_valid), 64'd0);
      end
      @(negedge clk);
      chk({v.name, " resp_valid"}, 64'(resp_valid), 64'd1);
      chk({v.name, " stall_resp"}, 64'(stall), 64'd0);
      chk({v.name, " rdata"}, resp_rdata, v.exp_rdata);
      chk({v.name, " err"}, 64'(resp_err), 64'(v.exp_err));
      @(negedge clk);
      chk({v.name, " pulse_end"}, 64'(resp_valid), 64'd0);
      chk({v.name, " rdata_hold"}, resp_rdata, v.exp_rdata);
   endtask

   vec_t vecs[$];

   initial begin
      int nresp;
      vecs = '{
         '{"ld10",      1'b0, 64'h10,  64'h0, 8'hFF, 64'h0, 1'b0},
         '{"st18",      1'b1, 64'h18,  64'hDEADBEEF_CAFEF00D, 8'hFF, 64'h0, 1'b0},
         '{"ld18",      1'b0, 64'h18,  64'h0, 8'hFF, 64'hDEADBEEF_CAFEF00D, 1'b0},
         '{"ld_wrap",   1'b0, 64'h18 + DEPTH*8, 64'h0, 8'hFF, 64'hDEADBEEF_CAFEF00D, 1'b0},
         '{"st_mis",    1'b1, 64'h1C,  64'h1234, 8'hFF, 64'h0, 1'b1},
         '{"ld18_keep", 1'b0, 64'h18,  64'h0, 8'hFF, 64'hDEADBEEF_CAFEF00D, 1'b0},
         '{"ld_mis",    1'b0, 64'h1F,  64'h0, 8'hFF, 64'h0, 1'b1},
         '{"st_top",    1'b1, 64'h1F8, 64'h01234567_89ABCDEF, 8'hFF, 64'h0, 1'b0},
         '{"ld_top_hi", 1'b0, 64'hFFFF_0000_0000_03F8, 64'h0, 8'hFF, 64'h01234567_89ABCDEF, 1'b0},
         '{"ld0",       1'b0, 64'h0,   64'h0, 8'hFF, 64'h0, 1'b0}
      };
`ifdef DATA_MEM_BYTE_STRB_EN
      vecs.push_back('{"st_strb_ff", 1'b1, 64'h40, 64'h11111111_11111111, 8'hFF, 64'h0, 1'b0});
      vecs.push_back('{"st_strb_0f", 1'b1, 64'h40, 64'hAAAAAAAA_AAAAAAAA, 8'h0F, 64'h0, 1'b0});
      vecs.push_back('{"ld_strb",    1'b0, 64'h40, 64'h0, 8'h00, 64'h11111111_AAAAAAAA, 1'b0});
      vecs.push_back('{"st_strb_00", 1'b1, 64'h40, 64'hFFFFFFFF_FFFFFFFF, 8'h00, 64'h0, 1'b0});
      vecs.push_back('{"ld_strb2",   1'b0, 64'h40, 64'h0, 8'hFF, 64'h11111111_AAAAAAAA, 1'b0});
`endif

      reset = 1'b1; req_valid = 1'b0; req_write = 1'b0;
      req_addr = 64'd0; req_wdata = 64'd0; req_strb = 8'hFF;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("rst resp_valid", 64'(resp_valid), 64'd0);
      chk("rst rdata", resp_rdata, 64'd0);
      chk("rst err", 64'(resp_err), 64'd0);
      chk("rst ready", 64'(req_ready), 64'd1);
      chk("rst stall", 64'(stall), 64'd0);

      foreach (vecs[i]) txn(vecs[i]);

      // Continuous req_valid, alternating loads of 0x18 and 0x1F8.
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b0; req_addr = 64'h18; req_strb = 8'hFF;
      nresp = 0;
      for (int k = 0; k < 4 * P; k++) begin
         int ph, rnd;
         ph = k % P; rnd = k / P;
         #1;
         chk("b2b ready", 64'(req_ready), 64'(ph == 0));
         chk("b2b stall", 64'(stall), 64'(ph != P - 1));
         chk("b2b resp_valid", 64'(resp_valid), 64'(ph == P - 1));
         if (resp_valid) begin
            nresp++;
            chk("b2b rdata", resp_rdata,
                (rnd % 2 == 0) ? 64'hDEADBEEF_CAFEF00D : 64'h01234567_89ABCDEF);
         end
         @(posedge clk); #1;
         if (ph == 0) req_addr = (rnd % 2 == 0) ? 64'h1F8 : 64'h18;
         if (k == 4 * P - 1) req_valid = 1'b0;
         @(negedge clk);
      end
      chk("b2b count", 64'(nresp), 64'd4);

      // Reset while a store is in flight; rdata is nonzero beforehand.
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b1; req_addr = 64'h20; req_wdata = 64'hFF;
      @(posedge clk); #1 req_valid = 1'b0;
      @(negedge clk);
      chk("rb busy stall", 64'(stall), 64'd1);
      reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
      @(negedge clk);
      chk("rb resp_valid", 64'(resp_valid), 64'd0);
      chk("rb rdata", resp_rdata, 64'd0);
      chk("rb err", 64'(resp_err), 64'd0);
      chk("rb ready", 64'(req_ready), 64'd1);
      chk("rb stall", 64'(stall), 64'd0);
      txn('{"ld20_dropped", 1'b0, 64'h20, 64'h0, 8'hFF, 64'h0, 1'b0});
      txn('{"ld18_cleared", 1'b0, 64'h18, 64'h0, 8'hFF, 64'h0, 1'b0});

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end
endmodule
